// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: runs mult/multu/div/divu and mthi/mtlo/mfhi/mflo, and owns the HI/LO registers.
// Latency: mult/multu commit after 5 busy cycles; div/divu commit after 10; mthi/mtlo write on the next edge; mduo is combinational.
// Backpressure: while busy, new starts are ignored, and stall holds the D-stage MDU instruction until the unit can accept it.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  md_type,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_wr_q, res_wr_d;

  logic        go;
  logic        is_mul;
  logic        is_div;
  logic        div_sgn;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  assign busy   = (state_q != S_IDLE);
  assign go     = start & ~cancel & ~busy;
  assign is_mul = (md_type == 5'd4) | (md_type == 5'd5);
  assign is_div = (md_type == 5'd6) | (md_type == 5'd7);
  assign stall  = d_is_md & (busy | (start & ~cancel & (is_mul | is_div)));

  // Products: sign-extending to 64 bits makes a plain unsigned multiply yield the signed result modulo 2^64.
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Divide on magnitudes, then restore signs; this also gives 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
  assign div_sgn = (md_type == 5'd6);
  assign num     = (div_sgn & a[31]) ? (32'd0 - a) : a;
  assign den     = (div_sgn & b[31]) ? (32'd0 - b) : b;
  assign q_u     = (den == 32'd0) ? 32'd0 : (num / den);
  assign r_u     = (den == 32'd0) ? 32'd0 : (num % den);
  assign quot    = (div_sgn & (a[31] ^ b[31])) ? (32'd0 - q_u) : q_u;
  assign rem     = (div_sgn & a[31]) ? (32'd0 - r_u) : r_u;

  // Next-state: launch/count down the busy window, stage results at go, commit them on the last busy edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = 4'd5;
            res_hi_d = (md_type == 5'd4) ? prod_s[63:32] : prod_u[63:32];
            res_lo_d = (md_type == 5'd4) ? prod_s[31:0]  : prod_u[31:0];
            res_wr_d = 1'b1;
          end else if (is_div) begin
            state_d  = S_DIV;
            cnt_d    = 4'd10;
            res_hi_d = rem;
            res_lo_d = quot;
            // A zero divisor still burns the full busy window but leaves HI/LO untouched.
            res_wr_d = (b != 32'd0);
          end else if (md_type == 5'd2) begin
            hi_d = a;
          end else if (md_type == 5'd3) begin
            lo_d = a;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; reset wins over both a new launch and a pending commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  // Move-from result is a pure mux of the architectural registers.
  always_comb begin
    mduo = 32'd0;
    if (md_type == 5'd0) mduo = hi_q;
    else if (md_type == 5'd1) mduo = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO and busy lengths are queued at issue and checked at completion.
// Inputs change and outputs are sampled on the falling edge.
// A bounded busy wait keeps every step terminating.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  md_type;
  logic        start;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mduo;

  int passes = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .md_type (md_type),
    .start   (start),
    .cancel  (cancel),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .mduo    (mduo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Issue one operation, queue its expectation, wait out busy, then compare.
  task automatic run_op(input string tag, input logic [4:0] t, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int ecyc, input bit poke);
    int n;
    logic [63:0] e;
    int ec;
    exp_q.push_back({eh, el});
    cyc_q.push_back(ecyc);
    @(negedge clk);
    md_type = t; a = av; b = bv; start = 1'b1; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0; md_type = 5'd31;
    if (poke) begin
      start = 1'b1; md_type = 5'd3; a = 32'hDEADBEEF;
    end
    n = 0;
    while (busy && n < 40) begin
      n++;
      a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0; md_type = 5'd31;
    end
    e  = exp_q.pop_front();
    ec = cyc_q.pop_front();
    chk({tag, "_cycles"}, n, ec);
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
  endtask

  initial begin
    int n;
    bit stall_ok;
    reset = 1'b1; md_type = 5'd31; start = 1'b0; cancel = 1'b0;
    a = 32'd0; b = 32'd0; d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Arithmetic directed cases
    run_op("mult", 5'd4, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);
    run_op("multu", 5'd5, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
    md_type = 5'd1;
    #1 chk("mflo", mduo, 32'hFFFFFFFE);
    md_type = 5'd0;
    #1 chk("mfhi", mduo, 32'h00000001);
    md_type = 5'd9;
    #1 chk("mf_none", mduo, 32'd0);
    run_op("div_neg", 5'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_op("mthi", 5'd2, 32'h11, 32'd0, 32'h11, 32'hFFFFFFFD, 0, 1'b0);
    run_op("mtlo", 5'd3, 32'h22, 32'd0, 32'h11, 32'h22, 0, 1'b0);
    run_op("divu_zero", 5'd7, 32'd5, 32'd0, 32'h11, 32'h22, 10, 1'b0);
    run_op("div_ovf", 5'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 1'b0);
    run_op("divu_poke", 5'd7, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1);
    run_op("mult_pos", 5'd4, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 5, 1'b0);

    // Cancel suppresses a new mult and an mthi
    @(negedge clk);
    md_type = 5'd4; a = 32'd5; b = 32'd5; start = 1'b1; cancel = 1'b1; d_is_md = 1'b1;
    #1 chk("cancel_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; d_is_md = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h1);
    chk("cancel_lo", lo, 32'h23456780);
    md_type = 5'd2; a = 32'h77; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_mthi", hi, 32'h1);

    // Stall through a divide
    d_is_md = 1'b1;
    md_type = 5'd6; a = 32'd100; b = 32'd3; start = 1'b1;
    #1 chk("stall_start", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; md_type = 5'd31;
    n = 0; stall_ok = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_cycles", n, 32'd10);
    chk("stall_held", {31'd0, stall_ok}, 32'd1);
    chk("stall_after", {31'd0, stall}, 32'd0);
    chk("div_hi", hi, 32'd1);
    chk("div_lo", lo, 32'd33);

    // Reset in the fourth busy cycle aborts without commit
    md_type = 5'd4; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_type = 5'd31; d_is_md = 1'b0;
    md_type = 5'd6; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_c4", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_late_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
